// File: rtl/uart_pkg.sv
// Purpose: shared UART constants: parity-mode encodings and data-width defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Used by uart_rx, the transmitter and parity_calculator.
package uart_pkg;

   // Parity-mode encodings carried on the 2-bit pbit field.
   localparam logic [1:0] PAR_NONE = 2'd0;
   localparam logic [1:0] PAR_EVEN = 2'd1;
   localparam logic [1:0] PAR_ODD  = 2'd2;
   localparam logic [1:0] PAR_RSVD = 2'd3;

   // Default data-bus width.
   localparam int DBIT_DEFAULT = 8;

   // Width of the dbit (active data-bit count) field.
   localparam int DBIT_W = 4;

endpackage

// File: rtl/bit_mask_gen.sv
// Purpose: build a DBIT-wide mask of the active data bits from a bit count.
// Latency: combinational.
// Backpressure: none.
// Ports: dbit  - requested active bit count (values above DBIT saturate to DBIT)
//        mask  - 1 for every active bit position; MSB- or LSB-aligned by MSB_ALIGN
module bit_mask_gen
   import uart_pkg::*;
#(
   parameter int DBIT      = DBIT_DEFAULT,
   parameter bit MSB_ALIGN = 1'b1
) (
   input  logic [DBIT_W-1:0] dbit,
   output logic [DBIT-1:0]   mask
);

   int n_i;

   // Per-bit compare against the count instead of a variable part-select.
   // Counts larger than DBIT naturally select every bit, which gives
   // the min(dbit, DBIT) saturation for free.
   always_comb begin
      mask = '0;
      n_i  = int'(dbit);
      for (int i = 0; i < DBIT; i++) begin
         if (MSB_ALIGN) begin
            mask[i] = ((DBIT - 1 - i) < n_i);
         end else begin
            mask[i] = (i < n_i);
         end
      end
   end

endmodule

// File: rtl/parity_calculator.sv
// Purpose: even/odd UART parity over the active bits of a DBIT-wide word.
// Latency: 1 clk (registered output reflects the previous edge's inputs).
// Backpressure: none; no handshake or enable, result updates every edge.
// Ports: clk, reset_n (async active-low), data, dbit (active bit count),
//        pbit (0 none, 1 even, 2 odd, 3 reserved = none), parity (registered).
module parity_calculator
   import uart_pkg::*;
#(
   parameter int DBIT      = DBIT_DEFAULT,
   parameter bit MSB_ALIGN = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [DBIT-1:0]   data,
   input  logic [DBIT_W-1:0] dbit,
   input  logic [1:0]        pbit,
   output logic              parity
);

   logic [DBIT-1:0] mask;
   logic            x;
   logic            parity_nxt;

   bit_mask_gen #(
      .DBIT      (DBIT),
      .MSB_ALIGN (MSB_ALIGN)
   ) u_mask (
      .dbit (dbit),
      .mask (mask)
   );

   // Reduction XOR over the masked word; synthesises to a log-depth tree.
   assign x = ^(data & mask);

   always_comb begin
      parity_nxt = 1'b0;
      case (pbit)
         PAR_EVEN: parity_nxt = x;
         PAR_ODD:  parity_nxt = ~x;
         default:  parity_nxt = 1'b0;   // none and reserved both emit 0
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         parity <= 1'b0;
      end else begin
         parity <= parity_nxt;
      end
   end

endmodule

// File: tb/tb_parity_calculator.sv
module tb_parity_calculator;
   import uart_pkg::*;

   logic       clk;
   logic       reset_n;
   logic [7:0] data;
   logic [3:0] dbit;
   logic [1:0] pbit;
   logic       par_m;   // MSB_ALIGN = 1 instance
   logic       par_l;   // MSB_ALIGN = 0 instance

   int checks;
   int errors;

   parity_calculator #(.DBIT(8), .MSB_ALIGN(1'b1)) dut_m (
      .clk     (clk),
      .reset_n (reset_n),
      .data    (data),
      .dbit    (dbit),
      .pbit    (pbit),
      .parity  (par_m)
   );

   parity_calculator #(.DBIT(8), .MSB_ALIGN(1'b0)) dut_l (
      .clk     (clk),
      .reset_n (reset_n),
      .data    (data),
      .dbit    (dbit),
      .pbit    (pbit),
      .parity  (par_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   // Drive inputs on the falling edge, then sample 1 time unit after the rising edge.
   task automatic apply(input logic [7:0] d, input logic [3:0] n, input logic [1:0] p);
      @(negedge clk);
      data = d;
      dbit = n;
      pbit = p;
      @(posedge clk);
      #1;
   endtask

   // Reference: shift/mask out the active field, then count ones.
   function automatic logic ref_par(input logic [7:0] d, input logic [3:0] nb,
                                    input logic [1:0] p, input bit msb);
      int         n;
      int         ones;
      logic [7:0] act;
      n = (nb > 4'd8) ? 8 : int'(nb);
      if (msb) act = 8'(d >> (8 - n));
      else     act = d & 8'((1 << n) - 1);
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(act[i]);
      case (p)
         2'd1:    return (ones % 2) == 1;
         2'd2:    return (ones % 2) == 0;
         default: return 1'b0;
      endcase
   endfunction

   initial begin
      logic prev_m;
      logic prev_l;
      logic exp_m;
      logic exp_l;
      checks  = 0;
      errors  = 0;

      // Reset with inputs that would otherwise produce 1.
      reset_n = 1'b0;
      data    = 8'h01;
      dbit    = 4'd8;
      pbit    = PAR_EVEN;
      #2;
      check("reset_init_m", par_m, 1'b0);
      check("reset_init_l", par_l, 1'b0);
      @(posedge clk); #1;
      check("reset_held_m", par_m, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      check("reset_release_m", par_m, 1'b1);
      check("reset_release_l", par_l, 1'b1);

      // Asynchronous clear mid-cycle, away from any edge.
      #2;
      reset_n = 1'b0;
      #1;
      check("async_clear_m", par_m, 1'b0);
      check("async_clear_l", par_l, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;

      // Even, 8 bits.
      apply(8'hA5, 4'd8, PAR_EVEN); check("even8_A5", par_m, 1'b0);
      apply(8'hA4, 4'd8, PAR_EVEN); check("even8_A4", par_m, 1'b1);
      check("even8_A4_lsb", par_l, 1'b1);

      // Odd, 8 bits.
      apply(8'hA5, 4'd8, PAR_ODD); check("odd8_A5", par_m, 1'b1);
      apply(8'h00, 4'd8, PAR_ODD); check("odd8_00", par_m, 1'b1);
      apply(8'hFF, 4'd8, PAR_ODD); check("odd8_FF", par_m, 1'b1);

      // 7-bit fields.
      apply(8'h03, 4'd7, PAR_EVEN); check("msb7_03", par_m, 1'b1);
      apply(8'h02, 4'd7, PAR_EVEN); check("msb7_02", par_m, 1'b1);
      apply(8'h06, 4'd7, PAR_EVEN); check("msb7_06", par_m, 1'b0);
      apply(8'h80, 4'd7, PAR_EVEN); check("lsb7_80", par_l, 1'b0);
      check("msb7_80", par_m, 1'b1);

      // No parity / reserved: always 0.
      for (int i = 0; i < 24; i++) begin
         apply(8'($urandom), 4'($urandom_range(0, 15)), (i % 2 == 0) ? PAR_NONE : PAR_RSVD);
         check($sformatf("nopar_m_%0d", i), par_m, 1'b0);
         check($sformatf("nopar_l_%0d", i), par_l, 1'b0);
      end

      // dbit = 0.
      apply(8'hFF, 4'd0, PAR_EVEN); check("dbit0_even_m", par_m, 1'b0);
      check("dbit0_even_l", par_l, 1'b0);
      apply(8'hFF, 4'd0, PAR_ODD);  check("dbit0_odd_m", par_m, 1'b1);
      check("dbit0_odd_l", par_l, 1'b1);

      // dbit above DBIT saturates to DBIT.
      apply(8'hA4, 4'd15, PAR_EVEN); check("dbit15_m", par_m, 1'b1);
      check("dbit15_l", par_l, 1'b1);
      apply(8'h81, 4'd15, PAR_ODD);  check("dbit15_odd_m", par_m, 1'b1);
      check("dbit15_odd_l", par_l, 1'b1);

      // Exhaustive data sweep, inputs changing every cycle. Before each
      // rising edge the output must still hold the previous result.
      prev_m = par_m;
      prev_l = par_l;
      for (int d = 0; d < 256; d++) begin
         @(negedge clk);
         data = 8'(d);
         dbit = 4'(d % 10);
         pbit = (d % 3 == 2) ? PAR_ODD : PAR_EVEN;
         exp_m = ref_par(8'(d), 4'(d % 10), pbit, 1'b1);
         exp_l = ref_par(8'(d), 4'(d % 10), pbit, 1'b0);
         #1;
         check($sformatf("hold_m_%0d", d), par_m, prev_m);
         check($sformatf("hold_l_%0d", d), par_l, prev_l);
         @(posedge clk); #1;
         check($sformatf("sweep_m_%0d", d), par_m, exp_m);
         check($sformatf("sweep_l_%0d", d), par_l, exp_l);
         prev_m = exp_m;
         prev_l = exp_l;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
